// File: rtl/ecp5_dpr16x4_fifo_ctrl.sv
// rtl/ecp5_dpr16x4_fifo_ctrl.sv - FWFT FIFO controller for one TRELLIS_DPR16X4 LUTRAM
//
// Drives the write port of a 16x4 distributed RAM and captures its
// asynchronous read data in a single output register. The register counts
// as a 17th storage slot, so LEVEL runs 0..17.
//
// Ports:
//   CLK          in   single clock, also the RAM WCK
//   LSR          in   synchronous active-high reset
//   S_DATA[3:0]  in   write data
//   S_VALID      in   write request
//   S_READY      out  a write will be accepted this cycle
//   M_DATA[3:0]  out  registered read data
//   M_VALID      out  M_DATA holds a valid word
//   M_READY      in   consumer accepts M_DATA
//   RAM_DI[3:0]  out  RAM write data
//   RAM_WAD[3:0] out  RAM write address
//   RAM_WRE      out  RAM write enable, active high
//   RAM_RAD[3:0] out  RAM read address
//   RAM_DO[3:0]  in   RAM asynchronous read data
//   LEVEL[4:0]   out  words held (RAM plus output register)
//   ALMOST_FULL  out  LEVEL >= AFULL_LEVEL
//   ALMOST_EMPTY out  LEVEL <= AEMPTY_LEVEL

module ecp5_dpr16x4_fifo_ctrl #(
    parameter int AFULL_LEVEL  = 14,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic       CLK,
    input  logic       LSR,
    input  logic [3:0] S_DATA,
    input  logic       S_VALID,
    output logic       S_READY,
    output logic [3:0] M_DATA,
    output logic       M_VALID,
    input  logic       M_READY,
    output logic [3:0] RAM_DI,
    output logic [3:0] RAM_WAD,
    output logic       RAM_WRE,
    output logic [3:0] RAM_RAD,
    input  logic [3:0] RAM_DO,
    output logic [4:0] LEVEL,
    output logic       ALMOST_FULL,
    output logic       ALMOST_EMPTY
);

    localparam logic [4:0] AFULL_THR  = 5'(AFULL_LEVEL);
    localparam logic [4:0] AEMPTY_THR = 5'(AEMPTY_LEVEL);

    logic [3:0] wptr;
    logic [3:0] rptr;
    logic [4:0] rcnt;
    logic       push;
    logic       load;

    // S_READY looks only at the RAM occupancy: a pop this cycle frees a
    // slot next cycle, keeping M_READY out of the write-side timing path.
    assign S_READY = ~LSR & (rcnt != 5'd16);
    assign push    = S_VALID & S_READY;

    // Refill the output register whenever it is empty or being drained.
    // rcnt != 0 guarantees rptr != wptr, so the async read never sees the
    // word being written on this edge.
    assign load = (rcnt != 5'd0) & (~M_VALID | M_READY) & ~LSR;

    assign RAM_WRE = push;
    assign RAM_WAD = wptr;
    assign RAM_DI  = S_DATA;
    assign RAM_RAD = rptr;

    assign LEVEL        = rcnt + {4'd0, M_VALID};
    assign ALMOST_FULL  = (LEVEL >= AFULL_THR);
    assign ALMOST_EMPTY = (LEVEL <= AEMPTY_THR);

    always_ff @(posedge CLK) begin
        if (LSR) begin
            wptr    <= 4'd0;
            rptr    <= 4'd0;
            rcnt    <= 5'd0;
            M_VALID <= 1'b0;
            M_DATA  <= 4'h0;
        end else begin
            if (push) begin
                wptr <= wptr + 4'd1;
            end
            if (load) begin
                M_DATA  <= RAM_DO;
                M_VALID <= 1'b1;
                rptr    <= rptr + 4'd1;
            end else if (M_VALID & M_READY) begin
                M_VALID <= 1'b0;
            end
            rcnt <= rcnt + {4'd0, push} - {4'd0, load};
        end
    end

endmodule

// File: tb/tb_ecp5_dpr16x4_fifo_ctrl.sv
// tb/tb_ecp5_dpr16x4_fifo_ctrl.sv - directed bench for ecp5_dpr16x4_fifo_ctrl with a behavioural DPR16X4

module tb_ecp5_dpr16x4_fifo_ctrl;

    logic       CLK = 1'b0;
    logic       LSR;
    logic [3:0] S_DATA;
    logic       S_VALID;
    logic       S_READY;
    logic [3:0] M_DATA;
    logic       M_VALID;
    logic       M_READY;
    logic [3:0] RAM_DI;
    logic [3:0] RAM_WAD;
    logic       RAM_WRE;
    logic [3:0] RAM_RAD;
    logic [3:0] RAM_DO;
    logic [4:0] LEVEL;
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;

    logic [3:0] mem [16];

    int vectors = 0;
    int errors  = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (RAM_WRE) mem[RAM_WAD] <= RAM_DI;
    end
    assign RAM_DO = mem[RAM_RAD];

    ecp5_dpr16x4_fifo_ctrl #(
        .AFULL_LEVEL (14),
        .AEMPTY_LEVEL(1)
    ) dut (
        .CLK         (CLK),
        .LSR         (LSR),
        .S_DATA      (S_DATA),
        .S_VALID     (S_VALID),
        .S_READY     (S_READY),
        .M_DATA      (M_DATA),
        .M_VALID     (M_VALID),
        .M_READY     (M_READY),
        .RAM_DI      (RAM_DI),
        .RAM_WAD     (RAM_WAD),
        .RAM_WRE     (RAM_WRE),
        .RAM_RAD     (RAM_RAD),
        .RAM_DO      (RAM_DO),
        .LEVEL       (LEVEL),
        .ALMOST_FULL (ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then settle.
    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [3:0] exp_out;
        logic [3:0] held;
        logic       was_held;
        int         pushed;
        int         popped;
        int         cyc;

        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        LSR = 1'b1; S_VALID = 1'b1; S_DATA = 4'h7; M_READY = 1'b0;

        // Reset: write side blocked while LSR is high.
        #1;
        chk("rst_s_ready", {7'd0, S_READY}, 8'd0);
        chk("rst_ram_wre", {7'd0, RAM_WRE}, 8'd0);
        tick; tick;
        LSR = 1'b0; S_VALID = 1'b0;
        #1;
        chk("rst_level", {3'd0, LEVEL}, 8'd0);
        chk("rst_m_valid", {7'd0, M_VALID}, 8'd0);
        chk("rst_m_data", {4'd0, M_DATA}, 8'h0);
        chk("rst_afull", {7'd0, ALMOST_FULL}, 8'd0);
        chk("rst_aempty", {7'd0, ALMOST_EMPTY}, 8'd1);

        // 1: single push, 2-edge latency.
        S_VALID = 1'b1; S_DATA = 4'hA;
        #1;
        chk("t1_wre", {7'd0, RAM_WRE}, 8'd1);
        chk("t1_wad", {4'd0, RAM_WAD}, 8'd0);
        tick;
        S_VALID = 1'b0;
        #1;
        chk("t1_mv_after_1", {7'd0, M_VALID}, 8'd0);
        chk("t1_level_after_1", {3'd0, LEVEL}, 8'd1);
        tick;
        chk("t1_mv_after_2", {7'd0, M_VALID}, 8'd1);
        chk("t1_md_after_2", {4'd0, M_DATA}, 8'hA);
        chk("t1_level_after_2", {3'd0, LEVEL}, 8'd1);

        // Reset again so pointers restart at 0.
        LSR = 1'b1; tick; LSR = 1'b0; #1;

        // 2: fill to 17 with M_READY=0.
        for (int i = 0; i < 17; i++) begin
            S_VALID = 1'b1; S_DATA = (i == 16) ? 4'h1 : 4'(i);
            #1;
            chk("t2_s_ready", {7'd0, S_READY}, 8'd1);
            tick;
        end
        chk("t2_m_data", {4'd0, M_DATA}, 8'h0);
        chk("t2_level", {3'd0, LEVEL}, 8'd17);
        chk("t2_afull", {7'd0, ALMOST_FULL}, 8'd1);
        chk("t2_s_ready_full", {7'd0, S_READY}, 8'd0);
        S_DATA = 4'hE;
        #1;
        chk("t2_18th_wre", {7'd0, RAM_WRE}, 8'd0);
        tick;
        chk("t2_level_hold", {3'd0, LEVEL}, 8'd17);
        S_VALID = 1'b0;

        // 3: drain 17 words, RAM_RAD wraps F -> 0.
        M_READY = 1'b1;
        for (int i = 0; i < 17; i++) begin
            #1;
            chk("t3_m_valid", {7'd0, M_VALID}, 8'd1);
            chk("t3_m_data", {4'd0, M_DATA}, (i == 16) ? 8'h1 : 8'(i));
            chk("t3_rad", {4'd0, RAM_RAD}, 8'((i + 1) % 16));
            tick;
        end
        chk("t3_level", {3'd0, LEVEL}, 8'd0);
        chk("t3_m_valid_end", {7'd0, M_VALID}, 8'd0);
        chk("t3_aempty", {7'd0, ALMOST_EMPTY}, 8'd1);

        // 4: streaming 40 words with M_READY=1.
        exp_out = 4'h0; popped = 0;
        for (int i = 0; i < 40; i++) begin
            S_VALID = 1'b1; S_DATA = 4'(i);
            #1;
            if (i >= 2) begin
                chk("t4_throughput", {7'd0, M_VALID}, 8'd1);
                chk("t4_level", {3'd0, LEVEL}, 8'd2);
            end
            if (M_VALID) begin
                chk("t4_data", {4'd0, M_DATA}, {4'd0, exp_out});
                exp_out++; popped++;
            end
            tick;
        end
        S_VALID = 1'b0;
        cyc = 0;
        while (cyc < 10 && (M_VALID || LEVEL != 5'd0)) begin
            #1;
            if (M_VALID) begin
                chk("t4_drain_data", {4'd0, M_DATA}, {4'd0, exp_out});
                exp_out++; popped++;
            end
            tick;
            cyc++;
        end
        chk("t4_count", 8'(popped), 8'd40);
        chk("t4_empty", {3'd0, LEVEL}, 8'd0);

        // 5: backpressure, M_READY toggles every cycle.
        exp_out = 4'h3; pushed = 0; popped = 0; was_held = 1'b0; held = 4'h0;
        for (int i = 0; i < 40; i++) begin
            S_VALID = (pushed < 20);
            S_DATA  = 4'(pushed + 3);
            M_READY = i[0];
            #1;
            if (was_held) chk("t5_hold", {4'd0, M_DATA}, {4'd0, held});
            was_held = M_VALID & ~M_READY;
            held     = M_DATA;
            if (M_VALID && M_READY) begin
                chk("t5_data", {4'd0, M_DATA}, {4'd0, exp_out});
                exp_out++; popped++;
            end
            if (S_VALID && S_READY) pushed++;
            tick;
        end
        S_VALID = 1'b0; M_READY = 1'b1;
        cyc = 0;
        while (cyc < 30 && (M_VALID || LEVEL != 5'd0)) begin
            #1;
            if (M_VALID) begin
                chk("t5_drain_data", {4'd0, M_DATA}, {4'd0, exp_out});
                exp_out++; popped++;
            end
            tick;
            cyc++;
        end
        chk("t5_pushed", 8'(pushed), 8'd20);
        chk("t5_popped", 8'(popped), 8'd20);

        // 6: reset mid-stream at LEVEL=9 with a push pending.
        M_READY = 1'b0;
        for (int i = 0; i < 9; i++) begin
            S_VALID = 1'b1; S_DATA = 4'(i + 8);
            tick;
        end
        chk("t6_level9", {3'd0, LEVEL}, 8'd9);
        LSR = 1'b1; S_DATA = 4'hC;
        #1;
        chk("t6_rst_wre", {7'd0, RAM_WRE}, 8'd0);
        chk("t6_rst_s_ready", {7'd0, S_READY}, 8'd0);
        tick;
        LSR = 1'b0; S_VALID = 1'b0;
        #1;
        chk("t6_level", {3'd0, LEVEL}, 8'd0);
        chk("t6_m_valid", {7'd0, M_VALID}, 8'd0);
        chk("t6_wad", {4'd0, RAM_WAD}, 8'd0);
        chk("t6_rad", {4'd0, RAM_RAD}, 8'd0);
        S_VALID = 1'b1; S_DATA = 4'h5;
        tick;
        S_VALID = 1'b0;
        tick;
        chk("t6_m_valid_new", {7'd0, M_VALID}, 8'd1);
        chk("t6_m_data_new", {4'd0, M_DATA}, 8'h5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ecp5_dpr16x4_fifo_ctrl.md
Name: ecp5_dpr16x4_fifo_ctrl

Overview:
- Synchronous FWFT FIFO controller that drives one TRELLIS_DPR16X4 LUTRAM: it generates write address, write enable, write data and read address, and consumes the RAM's asynchronous read data.
- Adds one registered output stage, so the RAM's combinational read path is captured before leaving the block.
- Used by ECP5 techmap and test designs that need a 16x4 buffer built from distributed RAM.

Parameters:
- AFULL_LEVEL, 14: ALMOST_FULL asserts when LEVEL >= AFULL_LEVEL. Legal range 1..17.
- AEMPTY_LEVEL, 1: ALMOST_EMPTY asserts when LEVEL <= AEMPTY_LEVEL. Legal range 0..16.

Ports:
- CLK in 1: single clock; also drives the RAM's WCK.
- LSR in 1: synchronous active-high reset.
- S_DATA in 4: write data.
- S_VALID in 1: write request.
- S_READY out 1: controller can accept a write.
- M_DATA out 4: registered read data.
- M_VALID out 1: M_DATA holds a valid word.
- M_READY in 1: consumer accepts M_DATA.
- RAM_DI out 4: to DPR16X4 DI.
- RAM_WAD out 4: to DPR16X4 WAD.
- RAM_WRE out 1: to DPR16X4 WRE; active high.
- RAM_RAD out 4: to DPR16X4 RAD.
- RAM_DO in 4: from DPR16X4 DO; asynchronous read.
- LEVEL out 5: total words held, 0..17.
- ALMOST_FULL out 1: LEVEL >= AFULL_LEVEL.
- ALMOST_EMPTY out 1: LEVEL <= AEMPTY_LEVEL.

Behaviour:
- Clock and reset: one clock (CLK); reset LSR is synchronous and active-high.
- State registers:
  - wptr[3:0], rptr[3:0]: both wrap 15 -> 0.
  - rcnt[4:0]: words in RAM, 0..16.
  - M_VALID, M_DATA.
- Reset (LSR=1 at a CLK edge): wptr=0, rptr=0, rcnt=0, M_VALID=0, M_DATA=4'h0.
  - While LSR=1, S_READY=0 and RAM_WRE=0 combinationally.
  - RAM contents are not cleared.
  - Reset wins over any simultaneous push or pop; words in flight are discarded.
- Outputs after reset: LEVEL=0, ALMOST_FULL=(AFULL_LEVEL==0 ? 1 : 0), ALMOST_EMPTY=1.
- Write path (combinational to the RAM):
  - S_READY = ~LSR & (rcnt != 16).
  - push = S_VALID & S_READY.
  - RAM_WRE = push, RAM_WAD = wptr, RAM_DI = S_DATA.
  - The RAM commits on the same CLK edge; wptr increments on that edge.
- Read path:
  - RAM_RAD = rptr at all times.
  - load = (rcnt != 0) & (~M_VALID | M_READY) & ~LSR.
  - On load: M_DATA <= RAM_DO, M_VALID <= 1, rptr increments.
  - If M_VALID & M_READY & ~load: M_VALID <= 0 and M_DATA holds its value.
- rcnt update: rcnt <= rcnt + push - load.
- Latency: a word pushed into an empty FIFO appears on M_VALID/M_DATA 2 edges after the push edge. No bypass path.
- Throughput: with M_READY=1 and sustained pushes, one word per cycle in and out after the initial 2-cycle fill.
- Read/write hazards:
  - Same-address read/write is impossible. load requires rcnt>0, so rptr != wptr, or the RAM is full and push=0.
  - RAM_RAD may equal RAM_WAD only when rcnt==0, and then RAM_DO is ignored.
- Full: rcnt==16 -> S_READY=0. A pop on the same cycle frees a slot only on the next cycle; S_READY is not combinationally dependent on M_READY.
- Empty: rcnt==0 and M_VALID=0 -> LEVEL=0. M_READY is ignored when M_VALID=0.
- Reporting outputs:
  - LEVEL = rcnt + M_VALID. Maximum 17: 16 words in RAM plus 1 in the output register.
  - ALMOST_FULL and ALMOST_EMPTY are combinational from LEVEL.
- Simultaneous push and load: both occur; rcnt is unchanged.
- M_DATA stability: M_DATA is stable while M_VALID=1 and M_READY=0.

Test Plan:
1. Reset, then push 4'hA at t0 with M_READY=0 -> RAM_WRE=1, RAM_WAD=0 at t0; M_VALID=1, M_DATA=A after edge t0+1; LEVEL=1.
2. M_READY=0; push 4'h0..4'hF and then 4'h1 (17 pushes) -> M_DATA=0, rcnt=16, S_READY=0, LEVEL=17, ALMOST_FULL=1. An 18th S_VALID is held off with no RAM_WRE.
3. From the full state of scenario 2, M_READY=1 for 17 cycles with no pushes -> M_DATA sequence 0,1,...,F,1; RAM_RAD wraps F -> 0; ending LEVEL=0, ALMOST_EMPTY=1, M_VALID=0.
4. Streaming: S_VALID=1 and M_READY=1 for 40 cycles with an incrementing 4-bit pattern -> in-order output, one word per cycle after 2-cycle latency; LEVEL steady at 1 or 2; wptr and rptr wrap twice.
5. Backpressure: M_READY toggles 1/0 every cycle while pushing continuously -> M_DATA held constant whenever M_VALID=1 and M_READY=0; no loss or duplication.
6. Assert LSR for one cycle with LEVEL=9 while a push is pending -> RAM_WRE=0 and S_READY=0 that cycle; next cycle LEVEL=0, M_VALID=0, wptr=rptr=0; a fresh push of 4'h5 is read back as 5.
